// File: rtl/wb_arb_pkg.sv
// Shared types and load-extraction helper for the writeback arbiter.
// Struct types here describe the default 32-bit / 5-bit-address configuration.
package wb_arb_pkg;

  localparam int unsigned DefXlen = 32;
  localparam int unsigned DefRfAw = 5;
  localparam int unsigned MaxXlen = 64;

  typedef enum logic [1:0] {
    WbSelOpr  = 2'b00,
    WbSelLoad = 2'b01
  } wb_sel_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef struct packed {
    logic [DefXlen-1:0] data;
    logic [DefRfAw-1:0] rd;
  } ll_entry_t;

  typedef struct packed {
    logic [DefXlen-1:0] wb_data;
    logic [DefRfAw-1:0] wb_rd;
    logic               wb_en;
  } wb_arb_out_t;

  // Operates at the widest supported datapath; callers cast to their XLEN.
  function automatic logic [MaxXlen-1:0] load_extract(input logic [MaxXlen-1:0] word,
                                                      input logic [2:0]         funct3,
                                                      input logic [1:0]         addr_lo);
    logic [7:0]         b;
    logic [15:0]        h;
    logic [MaxXlen-1:0] res;
    case (addr_lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      LB:      res = {{(MaxXlen-8){b[7]}}, b};
      LBU:     res = {{(MaxXlen-8){1'b0}}, b};
      LH:      res = {{(MaxXlen-16){h[15]}}, h};
      LHU:     res = {{(MaxXlen-16){1'b0}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_ll_fifo.sv
// Synchronous FIFO for long-latency writeback results.
// Publishes per-slot valid bits and destination registers for hazard tracking.
module wb_ll_fifo
  import wb_arb_pkg::*;
#(
  parameter type         entry_t = ll_entry_t,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned RF_AW   = DefRfAw,
  localparam int unsigned PtrW   = $clog2(DEPTH),
  localparam int unsigned CntW   = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  output entry_t           head,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count,
  output logic [DEPTH-1:0] valid,
  output logic [RF_AW-1:0] rd_vec [DEPTH]
);

  entry_t           mem_q [DEPTH];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [CntW-1:0]  count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  always_comb begin
    valid_d = valid_q;
    if (pop)  valid_d[rd_q] = 1'b0;
    if (push) valid_d[wr_q] = 1'b1;
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PtrW'(1);
      if (pop)  rd_q <= rd_q + PtrW'(1);
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Storage needs no reset; valid_q qualifies every slot.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_entry;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) rd_vec[i] = mem_q[i].rd;
  end

  assign head  = mem_q[rd_q];
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign valid = valid_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: in-order pipeline results take priority over buffered
// long-latency results; starved buffered results raise a stall request.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RF_AW      = 5,
  parameter int unsigned LL_DEPTH   = 4,
  parameter int unsigned MAX_STARVE = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_valid,
  input  logic                       pipe_wb_en,
  input  logic [1:0]                 pipe_wb_sel,
  input  logic [XLEN-1:0]            pipe_opr_res,
  input  logic [XLEN-1:0]            pipe_dmem_rdata,
  input  logic [2:0]                 pipe_ld_funct3,
  input  logic [1:0]                 pipe_addr_lo,
  input  logic [RF_AW-1:0]           pipe_rd,
  input  logic                       ll_valid,
  output logic                       ll_ready,
  input  logic [XLEN-1:0]            ll_data,
  input  logic [RF_AW-1:0]           ll_rd,
  output logic                       wb_en,
  output logic [RF_AW-1:0]           wb_rd,
  output logic [XLEN-1:0]            wb_data,
  output logic [2**RF_AW-1:0]        pending_mask,
  output logic                       stall_req,
  output logic [$clog2(LL_DEPTH):0]  ll_count
);

  localparam int unsigned StW = $clog2(MAX_STARVE + 1);

  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic [RF_AW-1:0] rd;
  } entry_t;

  typedef struct packed {
    logic [XLEN-1:0]  wb_data;
    logic [RF_AW-1:0] wb_rd;
    logic             wb_en;
  } out_t;

  logic             pipe_req, push, pop, full, empty;
  logic [XLEN-1:0]  sel_data;
  entry_t           head, push_entry;
  logic [LL_DEPTH-1:0] slot_valid;
  logic [RF_AW-1:0] slot_rd [LL_DEPTH];
  out_t             out_q, out_d;
  logic [StW-1:0]   starve_q, starve_d;
  logic             stall_q, stall_d;

  assign pipe_req = pipe_valid & pipe_wb_en & (pipe_rd != '0);
  assign sel_data = (wb_sel_e'(pipe_wb_sel) == WbSelLoad)
                  ? XLEN'(load_extract(MaxXlen'(pipe_dmem_rdata), pipe_ld_funct3, pipe_addr_lo))
                  : pipe_opr_res;

  assign ll_ready   = ~full;
  // rd==0 results are handshaked but never stored.
  assign push       = ll_valid & ~full & (ll_rd != '0);
  assign pop        = ~pipe_req & ~empty;
  assign push_entry = '{data: ll_data, rd: ll_rd};

  wb_ll_fifo #(
    .entry_t (entry_t),
    .DEPTH   (LL_DEPTH),
    .RF_AW   (RF_AW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (ll_count),
    .valid      (slot_valid),
    .rd_vec     (slot_rd)
  );

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < LL_DEPTH; i++) begin
      if (slot_valid[i]) pending_mask[slot_rd[i]] = 1'b1;
    end
  end

  always_comb begin
    out_d       = out_q;
    out_d.wb_en = 1'b0;
    if (pipe_req) begin
      out_d = '{wb_data: sel_data, wb_rd: pipe_rd, wb_en: 1'b1};
    end else if (pop) begin
      out_d = '{wb_data: head.data, wb_rd: head.rd, wb_en: 1'b1};
    end

    starve_d = '0;
    if (!empty && !pop) begin
      starve_d = (starve_q == StW'(MAX_STARVE)) ? starve_q : starve_q + StW'(1);
    end
    stall_d = (starve_d == StW'(MAX_STARVE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      out_q    <= out_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign wb_en     = out_q.wb_en;
  assign wb_rd     = out_q.wb_rd;
  assign wb_data   = out_q.wb_data;
  assign stall_req = stall_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model compared
// every cycle, plus hand-computed checkpoints from the directed scenarios.
module tb_wb_arbiter;

  localparam int unsigned Depth     = 4;
  localparam int unsigned MaxStarve = 8;

  logic        clk, rst;
  logic        pipe_valid, pipe_wb_en;
  logic [1:0]  pipe_wb_sel;
  logic [31:0] pipe_opr_res, pipe_dmem_rdata;
  logic [2:0]  pipe_ld_funct3;
  logic [1:0]  pipe_addr_lo;
  logic [4:0]  pipe_rd;
  logic        ll_valid, ll_ready;
  logic [31:0] ll_data;
  logic [4:0]  ll_rd;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] pending_mask;
  logic        stall_req;
  logic [2:0]  ll_count;

  wb_arbiter #(
    .XLEN       (32),
    .RF_AW      (5),
    .LL_DEPTH   (Depth),
    .MAX_STARVE (MaxStarve)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pipe_valid      (pipe_valid),
    .pipe_wb_en      (pipe_wb_en),
    .pipe_wb_sel     (pipe_wb_sel),
    .pipe_opr_res    (pipe_opr_res),
    .pipe_dmem_rdata (pipe_dmem_rdata),
    .pipe_ld_funct3  (pipe_ld_funct3),
    .pipe_addr_lo    (pipe_addr_lo),
    .pipe_rd         (pipe_rd),
    .ll_valid        (ll_valid),
    .ll_ready        (ll_ready),
    .ll_data         (ll_data),
    .ll_rd           (ll_rd),
    .wb_en           (wb_en),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .pending_mask    (pending_mask),
    .stall_req       (stall_req),
    .ll_count        (ll_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } m_entry_t;

  m_entry_t    m_q[$];
  logic        m_wb_en;
  logic [4:0]  m_wb_rd;
  logic [31:0] m_wb_data;
  int          m_blocked;
  logic        m_stall;

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3,
                                         input logic [1:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    int  size0;
    bit  preq, popped, accept;
    m_entry_t e;
    if (rst) begin
      m_q.delete();
      m_wb_en = 0; m_wb_rd = 0; m_wb_data = 0; m_blocked = 0; m_stall = 0;
    end else begin
      size0  = m_q.size();
      preq   = pipe_valid && pipe_wb_en && (pipe_rd != 0);
      accept = ll_valid && (size0 < Depth);
      popped = 0;
      if (preq) begin
        m_wb_en   = 1;
        m_wb_rd   = pipe_rd;
        m_wb_data = (pipe_wb_sel == 2'b01) ? m_load(pipe_dmem_rdata, pipe_ld_funct3, pipe_addr_lo)
                                           : pipe_opr_res;
      end else if (size0 > 0) begin
        e         = m_q.pop_front();
        m_wb_en   = 1;
        m_wb_rd   = e.rd;
        m_wb_data = e.data;
        popped    = 1;
      end else begin
        m_wb_en = 0;
      end
      if (size0 > 0 && !popped) m_blocked = (m_blocked < MaxStarve) ? m_blocked + 1 : MaxStarve;
      else m_blocked = 0;
      m_stall = (m_blocked == MaxStarve);
      if (accept && ll_rd != 0) m_q.push_back('{rd: ll_rd, data: ll_data});
    end
  end

  function automatic logic [31:0] m_pending();
    logic [31:0] m = 0;
    foreach (m_q[i]) m |= 32'd1 << m_q[i].rd;
    return m;
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      chk("cmp_wb_en",   64'(wb_en),        64'(m_wb_en));
      chk("cmp_wb_rd",   64'(wb_rd),        64'(m_wb_rd));
      chk("cmp_wb_data", 64'(wb_data),      64'(m_wb_data));
      chk("cmp_count",   64'(ll_count),     64'(m_q.size()));
      chk("cmp_ready",   64'(ll_ready),     64'(m_q.size() < Depth));
      chk("cmp_pending", 64'(pending_mask), 64'(m_pending()));
      chk("cmp_stall",   64'(stall_req),    64'(m_stall));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input logic v, input logic en, input logic [1:0] sel,
                          input logic [31:0] opr, input logic [4:0] rd);
    pipe_valid = v; pipe_wb_en = en; pipe_wb_sel = sel; pipe_opr_res = opr; pipe_rd = rd;
  endtask

  logic [2:0]  ld_f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
  logic [1:0]  ld_a   [4] = '{2'd3, 2'd2, 2'd2, 2'd0};
  logic [31:0] ld_exp [4] = '{32'hFFFF_FF80, 32'h0000_00F0, 32'hFFFF_80F0, 32'h0000_7F01};

  initial begin
    rst = 1;
    set_pipe(0, 0, 2'b00, 0, 0);
    pipe_dmem_rdata = 0; pipe_ld_funct3 = 0; pipe_addr_lo = 0;
    ll_valid = 0; ll_data = 0; ll_rd = 0;
    tick();
    check_en = 1;
    tick();
    rst = 0;
    chk("rst_wb_en", 64'(wb_en), 64'd0);
    chk("rst_count", 64'(ll_count), 64'd0);
    chk("rst_ready", 64'(ll_ready), 64'd1);
    chk("rst_stall", 64'(stall_req), 64'd0);

    // Pipeline ALU result, one-cycle latency
    set_pipe(1, 1, 2'b00, 32'h1234_5678, 5'd5);
    tick();
    chk("alu_wb_en",   64'(wb_en), 64'd1);
    chk("alu_wb_rd",   64'(wb_rd), 64'd5);
    chk("alu_wb_data", 64'(wb_data), 64'h1234_5678);

    // Load extraction
    set_pipe(1, 1, 2'b01, 32'h0, 5'd6);
    pipe_dmem_rdata = 32'h80F0_7F01;
    for (int i = 0; i < 4; i++) begin
      pipe_ld_funct3 = ld_f3[i]; pipe_addr_lo = ld_a[i];
      tick();
      chk($sformatf("load_%0d", i), 64'(wb_data), 64'(ld_exp[i]));
    end
    pipe_ld_funct3 = 3'b010; pipe_addr_lo = 2'd1;
    tick();
    chk("load_lw", 64'(wb_data), 64'h80F0_7F01);
    set_pipe(1, 1, 2'b10, 32'hA5A5_0001, 5'd6);
    tick();
    chk("sel_reserved", 64'(wb_data), 64'hA5A5_0001);

    // Idle and rd==0 pipeline write: no wb, address/data hold
    set_pipe(1, 1, 2'b00, 32'h5555_5555, 5'd0);
    tick();
    chk("idle_wb_en", 64'(wb_en), 64'd0);
    chk("idle_hold",  64'(wb_data), 64'hA5A5_0001);
    set_pipe(0, 0, 2'b00, 0, 0);

    // Single long-latency push, two-cycle latency to wb
    ll_valid = 1; ll_rd = 5'd7; ll_data = 32'hCAFE;
    tick();
    ll_valid = 0;
    chk("ll1_count",   64'(ll_count), 64'd1);
    chk("ll1_pending", 64'(pending_mask[7]), 64'd1);
    chk("ll1_no_wb",   64'(wb_en), 64'd0);
    tick();
    chk("ll1_wb_en",   64'(wb_en), 64'd1);
    chk("ll1_wb_rd",   64'(wb_rd), 64'd7);
    chk("ll1_wb_data", 64'(wb_data), 64'hCAFE);
    chk("ll1_pend_clr", 64'(pending_mask[7]), 64'd0);

    // Fill FIFO while pipeline holds the port; then starve into stall
    set_pipe(1, 1, 2'b00, 32'h3333, 5'd3);
    ll_valid = 1;
    for (int i = 0; i < 4; i++) begin
      ll_rd = 5'(8 + i); ll_data = 32'h100 + 32'(i);
      tick();
    end
    ll_rd = 5'd20; ll_data = 32'hBAD;
    chk("full_ready",   64'(ll_ready), 64'd0);
    chk("full_count",   64'(ll_count), 64'd4);
    chk("full_pending", 64'(pending_mask), 64'h0000_0F00);
    for (int i = 0; i < 4; i++) tick();
    chk("stall_pre", 64'(stall_req), 64'd0);
    tick();
    chk("stall_set", 64'(stall_req), 64'd1);
    ll_valid = 0;
    set_pipe(0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("drain_rd_%0d", i),   64'(wb_rd), 64'(8 + i));
      chk($sformatf("drain_data_%0d", i), 64'(wb_data), 64'h100 + 64'(i));
      if (i == 0) chk("stall_clr", 64'(stall_req), 64'd0);
    end
    tick();
    chk("drain_done", 64'(wb_en), 64'd0);

    // rd==0 long-latency result is accepted but dropped
    ll_valid = 1; ll_rd = 5'd0; ll_data = 32'hDEAD;
    chk("rd0_ready", 64'(ll_ready), 64'd1);
    tick();
    ll_valid = 0;
    chk("rd0_count", 64'(ll_count), 64'd0);
    tick();
    chk("rd0_no_wb", 64'(wb_en), 64'd0);

    // Streaming push with concurrent pop keeps occupancy at one
    ll_valid = 1;
    for (int i = 0; i < 3; i++) begin
      ll_rd = 5'(12 + i); ll_data = 32'h200 + 32'(i);
      tick();
    end
    ll_valid = 0;
    tick();
    tick();

    // Reset with three entries buffered
    set_pipe(1, 1, 2'b00, 32'h4444, 5'd4);
    ll_valid = 1;
    for (int i = 0; i < 3; i++) begin
      ll_rd = 5'(16 + i); ll_data = 32'h300 + 32'(i);
      tick();
    end
    chk("pre_rst_count", 64'(ll_count), 64'd3);
    ll_valid = 0;
    set_pipe(0, 0, 2'b00, 0, 0);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_count",   64'(ll_count), 64'd0);
    chk("mid_rst_pending", 64'(pending_mask), 64'd0);
    chk("mid_rst_wb_en",   64'(wb_en), 64'd0);
    chk("mid_rst_stall",   64'(stall_req), 64'd0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Parametrised successor to the single-source writeback stage.
- Merges two writeback sources onto the one register-file write port:
  - the in-order pipeline result (ALU result or load data);
  - results from a long-latency unit (mul/div, late loads), buffered in a small FIFO.
- Performs load byte/half extraction and sign extension.
- Publishes a pending-rd mask for hazard detection.
- Raises a stall request when a buffered result has been starved too long.
- Sits between the MEM/WB pipeline register and the register file.

Parameters:
- XLEN, 32, datapath width.
- RF_AW, 5, register address width.
- LL_DEPTH, 4, long-latency FIFO entries (power of two, >=2).
- MAX_STARVE, 8, consecutive blocked cycles before stall_req asserts.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pipe_valid  in  1  pipeline writeback slot valid.
- pipe_wb_en  in  1  pipeline instruction writes rd.
- pipe_wb_sel  in  2  00 opr_res, 01 load data, 1x reserved (treated as opr_res).
- pipe_opr_res  in  XLEN  ALU result.
- pipe_dmem_rdata  in  XLEN  raw aligned data-memory word.
- pipe_ld_funct3  in  3  load size/sign.
- pipe_addr_lo  in  2  low two bits of the load address.
- pipe_rd  in  RF_AW  destination register.
- ll_valid  in  1  long-latency result offered.
- ll_ready  out  1  FIFO can accept.
- ll_data  in  XLEN  long-latency result.
- ll_rd  in  RF_AW  long-latency destination register.
- wb_en  out  1  register-file write enable (registered).
- wb_rd  out  RF_AW  write address (registered).
- wb_data  out  XLEN  write data (registered).
- pending_mask  out  2**RF_AW  bit r set while any FIFO entry targets rd r.
- stall_req  out  1  request a pipeline bubble (registered).
- ll_count  out  $clog2(LL_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: wb_en=0, wb_rd=0, wb_data=0, stall_req=0, FIFO empty (ll_count=0, pending_mask=0), starve counter=0. ll_ready=1 in the first cycle after reset deasserts.
- Pipeline write request: pipe_req = pipe_valid & pipe_wb_en & (pipe_rd!=0).
- Pipeline priority: if pipe_req, the next cycle registers wb_en=1, wb_rd=pipe_rd, wb_data=sel_data. Latency is 1 cycle.
- FIFO pop: if !pipe_req and the FIFO is non-empty, pop the head. The next cycle registers wb_en=1 with the head's rd/data.
- Idle: otherwise wb_en=0. wb_rd/wb_data hold their previous values.
- Push: ll_ready = !full, computed from registered occupancy. A push occurs when ll_valid & ll_ready.
  - Entries with ll_rd==0 are accepted (ll_ready honoured) but discarded without storage.
  - No bypass: minimum ll_valid-to-wb_en latency is 2 cycles.
- Simultaneous push and pop: legal at any occupancy except full. Occupancy is unchanged. When full, no push that cycle even if a pop occurs.
- Pointers: wrap modulo LL_DEPTH. An extra occupancy bit distinguishes full from empty.
- pending_mask: combinational OR over valid entries. The bit clears in the cycle after the entry's pop, when wb_en for it is high.
- Starve counter, per cycle:
  - FIFO non-empty and no pop: increment, saturating at MAX_STARVE.
  - pop or FIFO empty: counter = 0.
- stall_req: registered, =1 when the counter reaches MAX_STARVE. Cleared in the cycle after the pop. The pipeline contract is to deassert pipe_req while stall_req=1; if it does not, the pipeline still wins and no data is lost.
- Load extraction (wb_sel=01), byte lane = addr_lo, half lane = addr_lo[1]:
  - funct3 000 (LB), 100 (LBU): selected byte, sign- or zero-extended.
  - 001 (LH), 101 (LHU): selected half, sign- or zero-extended.
  - 010 (LW) and reserved encodings: full word.
- Reset mid-operation: all buffered entries are dropped and any in-flight wb is cancelled. The long-latency unit must also be reset.

Decomposition:
- Package wb_arb_pkg:
  - wb_sel_e enum;
  - load funct3 localparams (LB, LH, LW, LBU, LHU);
  - ll_entry_t packed struct {data, rd};
  - wb_arb_out_t struct {wb_data, wb_rd, wb_en}.
- Sub-module wb_ll_fifo: synchronous FIFO of ll_entry_t. Exposes full, empty, count, and the per-entry valid/rd vectors used to build pending_mask.
- Load extraction is a function in wb_arb_pkg.

Test Plan:
- Reset then pipe_valid=1, wb_en=1, wb_sel=00, opr_res=0x12345678, rd=5 -> next cycle wb_en=1, wb_rd=5, wb_data=0x12345678.
- Load dmem_rdata=0x80F0_7F01 with {funct3,addr_lo}={000,3},{100,2},{001,2},{101,0} -> wb_data=0xFFFF_FF80, 0x0000_00F0, 0xFFFF_80F0, 0x0000_7F01.
- Pipe idle, ll push rd=7, data=0xCAFE -> ll_count=1 and pending_mask[7]=1 after one cycle. Cycle after: wb_en=1, rd=7, data=0xCAFE, pending_mask[7]=0.
- Push 4 ll entries with pipe_req held high -> ll_ready=0 at count 4; stall_req=1 after 8 blocked cycles. Drop pipe_req -> entries drain in order over 4 cycles, and stall_req clears after the first pop.
- ll_rd=0 push -> ll_ready honoured, ll_count stays 0, no wb_en.
- Rst asserted with 3 entries buffered -> next cycle ll_count=0, pending_mask=0, wb_en=0, stall_req=0.
